// File: rtl/program_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// prog_seq_pkg
//   Shared types for the program_all run controller.
//   - state_t    : controller FSM states
//   - NUM_PROG   : number of programs the core can run
//   - prog_id_t  : program identifier (0..2)
//   - PROG_*     : program id constants
//   - lowest_set : picks the lowest-numbered pending program from a mask
// ----------------------------------------------------------------------------
package prog_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        RUN,
        LOG,
        DONE
    } state_t;

    localparam int NUM_PROG = 3;

    typedef logic [1:0] prog_id_t;

    localparam prog_id_t PROG_MULT  = 2'd0;
    localparam prog_id_t PROG_MATCH = 2'd1;
    localparam prog_id_t PROG_PAIR  = 2'd2;

    // Lowest set bit wins; the downward loop leaves the smallest index last.
    // Returns PROG_MULT for an empty mask (the caller checks |mask first).
    function automatic prog_id_t lowest_set(input logic [NUM_PROG-1:0] mask);
        prog_id_t id;
        id = PROG_MULT;
        for (int i = NUM_PROG - 1; i >= 0; i--) begin
            if (mask[i]) begin
                id = prog_id_t'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// ----------------------------------------------------------------------------
// program_sequencer_if
//   Control bundle between the host / core and program_sequencer.
//   Handshake semantics:
//     go        : single-cycle request, honoured only while the sequencer is
//                 idle (busy=0); prog_mask is captured on that same edge.
//     core_done : level from the core, qualified by the sequencer only while
//                 the core is out of reset (core_rst=0).
//     prog_done / all_done : single-cycle strobes; cyc_ct*/timeout/prog_sel
//                 are already valid in the strobe cycle.
//   Modports:
//     master : host/bench side (drives go, prog_mask, core_done)
//     slave  : sequencer side (drives everything else)
//   dbg_state exposes the controller FSM state for observation.
// ----------------------------------------------------------------------------
interface program_sequencer_if #(
    parameter int CT_W = 16
);
    import prog_seq_pkg::*;

    logic                  go;
    logic [NUM_PROG-1:0]   prog_mask;
    logic                  core_done;
    logic                  core_rst;
    prog_id_t              prog_sel;
    logic                  busy;
    logic                  prog_done;
    logic                  all_done;
    logic [NUM_PROG-1:0]   timeout;
    logic [CT_W-1:0]       cyc_ct0;
    logic [CT_W-1:0]       cyc_ct1;
    logic [CT_W-1:0]       cyc_ct2;
    state_t                dbg_state;

    modport master (
        output go, prog_mask, core_done,
        input  core_rst, prog_sel, busy, prog_done, all_done, timeout,
        input  cyc_ct0, cyc_ct1, cyc_ct2, dbg_state
    );

    modport slave (
        input  go, prog_mask, core_done,
        output core_rst, prog_sel, busy, prog_done, all_done, timeout,
        output cyc_ct0, cyc_ct1, cyc_ct2, dbg_state
    );

endinterface

// File: rtl/program_sequencer_run_watchdog.sv
// ----------------------------------------------------------------------------
// run_watchdog
//   RUN-phase cycle counter with synchronous clear and count enable.
//   Ports:
//     clk, reset : clock, asynchronous active-low reset
//     i_clr      : clear the counter (takes priority over i_en)
//     i_en       : advance the counter by one
//     o_next     : counter value including the current cycle (count + 1)
//     o_limit    : o_next has reached TIMEOUT_CYC
//   The controller leaves RUN when o_limit is seen, so the counter never
//   has to wrap (TIMEOUT_CYC < 2**CT_W).
// ----------------------------------------------------------------------------
module run_watchdog #(
    parameter int CT_W        = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clr,
    input  logic            i_en,
    output logic [CT_W-1:0] o_next,
    output logic            o_limit
);

    logic [CT_W-1:0] r_count;
    logic [CT_W-1:0] w_next;

    assign w_next  = r_count + CT_W'(1);
    assign o_next  = w_next;
    assign o_limit = (w_next == CT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// ----------------------------------------------------------------------------
// program_sequencer
//   Runs the enabled programs of the program_all core back to back (lowest id
//   first). For each one: hold the core in reset for RST_CYC cycles, release
//   it, wait for core_done under a watchdog, log the RUN cycle count.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-low reset; deassertion expected synchronous
//     bus   : program_sequencer_if slave modport (go/prog_mask/core_done in;
//             core_rst, prog_sel, busy, prog_done, all_done, timeout,
//             cyc_ct0..2, dbg_state out)
//   All outputs are registered.
// ----------------------------------------------------------------------------
module program_sequencer
    import prog_seq_pkg::*;
#(
    parameter int RST_CYC     = 2,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    program_sequencer_if.slave  bus
);

    state_t                r_state;
    logic [NUM_PROG-1:0]   r_mask;
    prog_id_t              r_sel;
    logic                  r_core_rst;
    logic                  r_busy;
    logic                  r_prog_done;
    logic                  r_all_done;
    logic [NUM_PROG-1:0]   r_timeout;
    logic [CT_W-1:0]       r_cyc_ct [NUM_PROG];
    logic [CT_W-1:0]       r_launch_ct;

    prog_id_t              w_pick;
    logic [NUM_PROG-1:0]   w_pick_oh;
    logic [CT_W-1:0]       w_next;
    logic                  w_limit;

    assign w_pick    = lowest_set(r_mask);
    assign w_pick_oh = NUM_PROG'(1) << w_pick;

    // Counter is zeroed throughout LAUNCH so the first RUN cycle counts 1.
    run_watchdog #(
        .CT_W        (CT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (r_state == LAUNCH),
        .i_en    (r_state == RUN),
        .o_next  (w_next),
        .o_limit (w_limit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_sel       <= PROG_MULT;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b0;
            r_prog_done <= 1'b0;
            r_all_done  <= 1'b0;
            r_timeout   <= '0;
            r_launch_ct <= '0;
            for (int i = 0; i < NUM_PROG; i++) begin
                r_cyc_ct[i] <= '0;
            end
        end else begin
            r_prog_done <= 1'b0;
            r_all_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_core_rst <= 1'b1;
                    if (bus.go) begin
                        r_mask    <= bus.prog_mask;
                        r_timeout <= '0;
                        for (int i = 0; i < NUM_PROG; i++) begin
                            r_cyc_ct[i] <= '0;
                        end
                        r_busy  <= 1'b1;
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    if (|r_mask) begin
                        r_sel       <= w_pick;
                        r_mask      <= r_mask & ~w_pick_oh;
                        r_launch_ct <= CT_W'(RST_CYC - 1);
                        r_state     <= LAUNCH;
                    end else begin
                        r_all_done <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                LAUNCH: begin
                    // core_done is deliberately not looked at here: it may
                    // still be asserted from the previous program.
                    if (r_launch_ct == '0) begin
                        r_core_rst <= 1'b0;
                        r_state    <= RUN;
                    end else begin
                        r_launch_ct <= r_launch_ct - CT_W'(1);
                    end
                end
                RUN: begin
                    // Done and limit in the same cycle: done wins, the count
                    // is identical either way, only the timeout flag differs.
                    if (bus.core_done || w_limit) begin
                        for (int i = 0; i < NUM_PROG; i++) begin
                            if (r_sel == prog_id_t'(i)) begin
                                r_cyc_ct[i] <= w_next;
                                if (!bus.core_done) begin
                                    r_timeout[i] <= 1'b1;
                                end
                            end
                        end
                        r_prog_done <= 1'b1;
                        r_core_rst  <= 1'b1;
                        r_state     <= LOG;
                    end
                end
                LOG: begin
                    r_state <= SELECT;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.core_rst  = r_core_rst;
    assign bus.prog_sel  = r_sel;
    assign bus.busy      = r_busy;
    assign bus.prog_done = r_prog_done;
    assign bus.all_done  = r_all_done;
    assign bus.timeout   = r_timeout;
    assign bus.cyc_ct0   = r_cyc_ct[0];
    assign bus.cyc_ct1   = r_cyc_ct[1];
    assign bus.cyc_ct2   = r_cyc_ct[2];
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_program_sequencer.sv
// ----------------------------------------------------------------------------
// tb_program_sequencer
//   Bench for program_sequencer. Each run's expected prog_done / all_done
//   snapshots, all_done cycle and launch count are derived from the mask and
//   the per-program core latencies, queued when go is issued, and compared
//   by an independent monitor whenever the sequencer strobes.
// ----------------------------------------------------------------------------
module tb_program_sequencer;
    import prog_seq_pkg::*;

    localparam int RST_CYC = 2;
    localparam int TMO     = 100;
    localparam int CT_W    = 16;
    localparam int W       = 1 + 2 + 3 + 3 * CT_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_sequencer_if #(.CT_W(CT_W)) bus ();

    program_sequencer #(
        .RST_CYC     (RST_CYC),
        .TIMEOUT_CYC (TMO),
        .CT_W        (CT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           exp_launch_q[$];
    int           n_checks  = 0;
    int           n_errors  = 0;
    int           done_seen = 0;
    logic [1:0]   model_sel = 2'd0;

    int           lat[3]    = '{0, 0, 0};
    bit           hold_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- core model ----------------
    // Raises core_done in the lat-th cycle after core_rst drops (0 = never);
    // hold_done keeps it high all the time, including during LAUNCH.
    int k = 0;
    always @(negedge clk) begin
        if (!reset) begin
            k = 0;
            bus.core_done = 1'b0;
        end else if (bus.core_rst) begin
            k = 0;
            bus.core_done = hold_done;
        end else begin
            k++;
            bus.core_done = hold_done ||
                            (lat[bus.prog_sel] != 0 && k >= lat[bus.prog_sel]);
        end
    end

    // ---------------- monitor ----------------
    int         hi_len     = 0;
    int         n_launch   = 0;
    bit         first      = 1'b0;
    bit         prev_hi    = 1'b1;
    bit         prev_busy  = 1'b0;
    logic [W-1:0] act_w;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.busy && !prev_busy) begin
                first    = 1'b1;
                n_launch = 0;
                hi_len   = 0;
            end
            if (!bus.core_rst) begin
                if (prev_hi && bus.busy) begin
                    // First launch: SELECT + RST_CYC; later: LOG + SELECT + RST_CYC.
                    check("rst_hold_len", 64'(hi_len), first ? 64'(RST_CYC + 1) : 64'(RST_CYC + 2));
                    first = 1'b0;
                    n_launch++;
                end
                hi_len = 0;
            end else if (bus.busy) begin
                hi_len++;
            end
            prev_hi   = bus.core_rst;
            prev_busy = bus.busy;

            if (bus.prog_done || bus.all_done) begin
                act_w = {bus.all_done, bus.prog_sel, bus.timeout,
                         bus.cyc_ct0, bus.cyc_ct1, bus.cyc_ct2};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got 0x%0h, nothing expected", act_w);
                end else begin
                    check("event", 64'(act_w), 64'(exp_q.pop_front()));
                end
                if (bus.all_done) begin
                    if (exp_cyc_q.size() != 0) begin
                        check("all_done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                        check("launch_count", 64'(n_launch), 64'(exp_launch_q.pop_front()));
                    end
                    done_seen++;
                end
            end
        end else begin
            prev_hi   = 1'b1;
            prev_busy = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Builds the expected outcome of a run from the rules, then pulses go.
    task automatic start_run(input logic [2:0] mask, input int l0, input int l1,
                             input int l2, input bit hold);
        int              la[3];
        logic [2:0]      tm;
        logic [CT_W-1:0] ct[3];
        int              total;
        int              nl;
        int              eff;
        bit              to;
        la        = '{l0, l1, l2};
        lat       = la;
        hold_done = hold;
        tm        = 3'b000;
        ct        = '{CT_W'(0), CT_W'(0), CT_W'(0)};
        total     = 0;
        nl        = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                if (hold) begin
                    eff = 1;   to = 1'b0;
                end else if (la[i] == 0 || la[i] > TMO) begin
                    eff = TMO; to = 1'b1;
                end else begin
                    eff = la[i]; to = 1'b0;
                end
                ct[i]     = CT_W'(eff);
                tm[i]     = to;
                total    += RST_CYC + eff + 2;
                nl++;
                model_sel = 2'(i);
                exp_q.push_back({1'b0, 2'(i), tm, ct[0], ct[1], ct[2]});
            end
        end
        exp_q.push_back({1'b1, model_sel, tm, ct[0], ct[1], ct[2]});
        exp_cyc_q.push_back(cyc + 2 + total);
        exp_launch_q.push_back(nl);
        bus.go        = 1'b1;
        bus.prog_mask = mask;
        @(negedge clk);
        bus.go        = 1'b0;
        bus.prog_mask = 3'($urandom_range(0, 7));
    endtask

    // Waits for all_done; optionally pulses go (new random mask) while busy.
    task automatic wait_done(input int poke_at);
        int start;
        int budget;
        start  = done_seen;
        budget = 3 * (TMO + RST_CYC + 4) + 20;
        for (int i = 0; i < budget && done_seen == start; i++) begin
            @(negedge clk);
            if (i == poke_at && bus.busy) begin
                bus.go        = 1'b1;
                bus.prog_mask = 3'($urandom_range(1, 7));
                @(negedge clk);
                bus.go        = 1'b0;
            end
        end
        if (done_seen == start) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout: all_done not seen within %0d cycles", budget);
        end else begin
            @(negedge clk);
            check("busy_after_done", 64'(bus.busy), 64'(0));
            check("queue_drained", 64'(exp_q.size()), 64'(0));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name,
              64'({bus.core_rst, bus.busy, bus.prog_done, bus.all_done, bus.prog_sel,
                   bus.timeout, bus.cyc_ct0, bus.cyc_ct1, bus.cyc_ct2}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 48'd0}));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int  found;
        int  m;
        int  l[3];
        bus.go        = 1'b0;
        bus.prog_mask = 3'b000;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        check("reset_state", 64'(bus.dbg_state), 64'(IDLE));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // all three programs in order
        start_run(3'b111, 40, 70, 90, 1'b0);
        wait_done(-1);
        // program 1 skipped
        start_run(3'b101, 40, 70, 90, 1'b0);
        wait_done(-1);
        // core never finishes: watchdog abort
        start_run(3'b010, 0, 0, 0, 1'b0);
        wait_done(-1);
        // done held high through LAUNCH: each program logs 1
        start_run(3'b111, 0, 0, 0, 1'b1);
        wait_done(-1);
        // done exactly at the limit wins; one past the limit times out
        start_run(3'b101, TMO, 0, TMO + 1, 1'b0);
        wait_done(-1);
        // empty mask, go pulsed again while busy
        start_run(3'b000, 0, 0, 0, 1'b0);
        wait_done(0);
        // go while a real run is busy
        start_run(3'b011, 20, 15, 0, 1'b0);
        wait_done(10);

        // reset in the middle of program 1's RUN
        start_run(3'b111, 30, 60, 90, 1'b0);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.prog_sel == 2'd1 && !bus.core_rst) begin
                found = 1;
                break;
            end
        end
        check("reached_prog1_run", 64'(found), 64'(1));
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midrun_reset_values");
        exp_q.delete();
        exp_cyc_q.delete();
        exp_launch_q.delete();
        model_sel = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start_run(3'b111, 12, 25, 7, 1'b0);
        wait_done(-1);

        // random runs
        for (int r = 0; r < 8; r++) begin
            m = $urandom_range(0, 7);
            for (int j = 0; j < 3; j++) begin
                l[j] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 10);
            end
            start_run(3'(m), l[0], l[1], l[2], ($urandom_range(0, 9) == 0));
            wait_done($urandom_range(0, 1) ? $urandom_range(0, 20) : -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
